relu_backward: RTL and testbench

- Backward-pass gradient gate for the ReLU activation stage in the CNN datapath.
- During the forward pass it captures one mask bit per conv output: 1 when the forward input MSB was 0, i.e. ReLU passed the value through.
- During the backward pass it returns each incoming gradient unchanged where the mask is 1, and forces it to zero where the mask is 0.
- Masks are consumed in the same element order they were captured (FIFO order).

---
 rtl/cnn_pkg.sv | 16 +
 rtl/relu_mask_fifo.sv | 76 +++++++
 rtl/relu_backward.sv | 86 ++++++++
 tb/tb_relu_backward.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
//   DWIDTH_DEFAULT : default activation/gradient width
//   MASK_PASS      : mask value meaning ReLU passed the value (gradient flows)
//   MASK_BLOCK     : mask value meaning ReLU clamped to zero (gradient blocked)
package cnn_pkg;

  localparam int unsigned DWIDTH_DEFAULT = 32;
  localparam logic        MASK_PASS      = 1'b1;
  localparam logic        MASK_BLOCK     = 1'b0;

  // A non-negative forward input (sign bit clear) is passed by ReLU.
  function automatic logic relu_mask(input logic sign_bit);
    return sign_bit ? MASK_BLOCK : MASK_PASS;
  endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// 1-bit synchronous FIFO holding one ReLU mask bit per forward element.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear           : synchronous flush (pointers and count), wins over push/pop
//   push, push_data : write one mask bit (caller guarantees !full)
//   pop, pop_data   : read the mask at the head (caller guarantees !empty)
//   full, empty     : occupancy flags derived from count
//   count           : number of stored masks, registered
module relu_mask_fifo
  import cnn_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            push,
  input  logic            push_data,
  input  logic            pop,
  output logic            pop_data,
  output logic            full,
  output logic            empty,
  output logic [AWIDTH:0] count
);

  localparam logic [AWIDTH:0] FullCount = (AWIDTH + 1)'(DEPTH);

  logic [DEPTH-1:0]  mask_q;
  logic [AWIDTH-1:0] wptr_q, wptr_d;
  logic [AWIDTH-1:0] rptr_q, rptr_d;
  logic [AWIDTH:0]   count_q, count_d;

  // Pointers are exactly AWIDTH bits, so DEPTH-1 -> 0 wrap is free.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Mask storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push && !clear) mask_q[wptr_q] <= push_data;
  end

  assign pop_data = mask_q[rptr_q];
  assign full     = (count_q == FullCount);
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/relu_backward.sv
// ReLU backward-pass gradient gate.
// Captures one mask bit per forward element and, in the same order, passes each
// incoming gradient through where the forward value was non-negative, else zero.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   Clear                           : synchronous flush of masks and output stage
//   FwdValid/FwdData/FwdReady       : forward activation stream (only the sign bit used)
//   GradValid/GradIn/GradReady      : incoming gradient stream
//   GradOutValid/GradOut/GradOutReady : gated gradient stream, one-cycle latency
//   MaskCount                       : number of masks currently stored
module relu_backward
  import cnn_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEFAULT,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Clear,
  input  logic              FwdValid,
  input  logic [DWIDTH-1:0] FwdData,
  output logic              FwdReady,
  input  logic              GradValid,
  input  logic [DWIDTH-1:0] GradIn,
  output logic              GradReady,
  output logic              GradOutValid,
  output logic [DWIDTH-1:0] GradOut,
  input  logic              GradOutReady,
  output logic [AWIDTH:0]   MaskCount
);

  logic wr_fire, rd_fire;
  logic fifo_full, fifo_empty, head_mask;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;

  relu_mask_fifo #(
    .DEPTH (DEPTH),
    .AWIDTH(AWIDTH)
  ) u_mask_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (Clear),
    .push     (wr_fire),
    .push_data(relu_mask(FwdData[DWIDTH-1])),
    .pop      (rd_fire),
    .pop_data (head_mask),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (MaskCount)
  );

  assign FwdReady  = !fifo_full && !Clear;
  // Accept a gradient only when the output slot is free or being drained this cycle.
  assign GradReady = !fifo_empty && (!out_valid_q || GradOutReady) && !Clear;
  assign wr_fire   = FwdValid && FwdReady;
  assign rd_fire   = GradValid && GradReady;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (Clear) begin
      out_valid_d = 1'b0;
    end else if (rd_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = (head_mask == MASK_PASS) ? GradIn : '0;
    end else if (GradOutReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign GradOutValid = out_valid_q;
  assign GradOut      = out_data_q;

endmodule

// File: tb/tb_relu_backward.sv
module tb_relu_backward;

  localparam int unsigned DW = 32;
  localparam int unsigned DP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          Clear;
  logic          FwdValid;
  logic [DW-1:0] FwdData;
  logic          FwdReady;
  logic          GradValid;
  logic [DW-1:0] GradIn;
  logic          GradReady;
  logic          GradOutValid;
  logic [DW-1:0] GradOut;
  logic          GradOutReady;
  logic [2:0]    MaskCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  relu_backward #(
    .DWIDTH(DW),
    .DEPTH (DP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Clear       (Clear),
    .FwdValid    (FwdValid),
    .FwdData     (FwdData),
    .FwdReady    (FwdReady),
    .GradValid   (GradValid),
    .GradIn      (GradIn),
    .GradReady   (GradReady),
    .GradOutValid(GradOutValid),
    .GradOut     (GradOut),
    .GradOutReady(GradOutReady),
    .MaskCount   (MaskCount)
  );

  typedef struct {
    logic [DW-1:0] fwd;
    logic [DW-1:0] grad;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    FwdValid  = 1'b0;
    GradValid = 1'b0;
    Clear     = 1'b0;
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    FwdValid = 1'b1;
    FwdData  = d;
    #1;
    check("push_ready", 32'(FwdReady), 32'd1);
    tick();
    FwdValid = 1'b0;
  endtask

  logic [DW-1:0] f[10];
  logic [DW-1:0] g[10];

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{fwd: 32'd5,          grad: 32'd10, exp: 32'd10};
    vecs[1] = '{fwd: -32'sd3,        grad: 32'd20, exp: 32'd0};
    vecs[2] = '{fwd: 32'd0,          grad: 32'd30, exp: 32'd30};
    vecs[3] = '{fwd: 32'h8000_0000,  grad: 32'd40, exp: 32'd0};

    rst_n = 1'b0; Clear = 1'b0; FwdValid = 1'b0; FwdData = '0;
    GradValid = 1'b0; GradIn = '0; GradOutReady = 1'b1;
    #12 rst_n = 1'b1;
    tick();
    check("rst_valid", 32'(GradOutValid), 32'd0);
    check("rst_out", GradOut, 32'd0);
    check("rst_count", 32'(MaskCount), 32'd0);
    check("rst_fwdrdy", 32'(FwdReady), 32'd1);
    check("rst_grdrdy", 32'(GradReady), 32'd0);

    // Basic gating, table driven
    for (int i = 0; i < 4; i++) push_one(vecs[i].fwd);
    #1;
    check("basic_full_count", 32'(MaskCount), 32'd4);
    check("basic_full_rdy", 32'(FwdReady), 32'd0);
    GradOutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      GradValid = 1'b1;
      GradIn    = vecs[i].grad;
      #1;
      check("basic_grdrdy", 32'(GradReady), 32'd1);
      tick();
      check("basic_valid", 32'(GradOutValid), 32'd1);
      check("basic_out", GradOut, vecs[i].exp);
      check("basic_count", 32'(MaskCount), 32'(3 - i));
    end
    GradValid = 1'b0;
    tick();
    check("basic_drain_valid", 32'(GradOutValid), 32'd0);

    // Full stall: masks pass, block, pass, pass, then 5th (block) stalls
    f[0] = 32'd1; f[1] = -32'sd1; f[2] = 32'd2; f[3] = 32'd3; f[4] = -32'sd9;
    for (int i = 0; i < 4; i++) push_one(f[i]);
    FwdValid = 1'b1; FwdData = f[4];
    #1;
    check("full_rdy", 32'(FwdReady), 32'd0);
    check("full_count", 32'(MaskCount), 32'd4);
    tick(); tick();
    check("full_hold_count", 32'(MaskCount), 32'd4);
    GradValid = 1'b1; GradIn = 32'd11;
    tick();
    GradValid = 1'b0;
    check("full_pop_out", GradOut, 32'd11);
    check("full_pop_count", 32'(MaskCount), 32'd3);
    tick();
    FwdValid = 1'b0;
    check("full_5th_count", 32'(MaskCount), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      GradValid = 1'b1; GradIn = 32'(i);
      tick();
      check("full_drain_out", GradOut, (f[i][DW-1] ? 32'd0 : 32'(i)));
    end
    GradValid = 1'b0;
    tick();

    // Empty stall
    GradValid = 1'b1; GradIn = 32'hdead;
    #1;
    check("empty_grdrdy", 32'(GradReady), 32'd0);
    tick();
    check("empty_valid", 32'(GradOutValid), 32'd0);
    check("empty_count", 32'(MaskCount), 32'd0);
    GradValid = 1'b0;

    // Backpressure
    push_one(32'd1); push_one(-32'sd1); push_one(32'd2);
    GradOutReady = 1'b1; GradValid = 1'b1; GradIn = 32'd100;
    tick();
    GradOutReady = 1'b0; GradIn = 32'd200;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_grdrdy", 32'(GradReady), 32'd0);
      tick();
      check("bp_out", GradOut, 32'd100);
      check("bp_valid", 32'(GradOutValid), 32'd1);
      check("bp_count", 32'(MaskCount), 32'd2);
    end
    GradOutReady = 1'b1;
    #1;
    check("bp_release_rdy", 32'(GradReady), 32'd1);
    tick();
    check("bp_out2", GradOut, 32'd0);
    GradIn = 32'd300;
    tick();
    check("bp_out3", GradOut, 32'd300);
    check("bp_count_end", 32'(MaskCount), 32'd0);
    GradValid = 1'b0;
    tick();
    check("bp_valid_end", 32'(GradOutValid), 32'd0);

    // Simultaneous push/pop at count 2
    for (int i = 0; i < 10; i++) begin
      f[i] = (i % 3 == 1) ? (32'h8000_0000 | 32'(i)) : 32'(i * 7);
      g[i] = 32'(1000 + i);
    end
    push_one(f[0]); push_one(f[1]);
    GradOutReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      FwdValid = 1'b1; FwdData = f[i + 2];
      GradValid = 1'b1; GradIn = g[i];
      tick();
      check("sim_out", GradOut, f[i][DW-1] ? 32'd0 : g[i]);
      check("sim_count", 32'(MaskCount), 32'd2);
    end
    FwdValid = 1'b0;
    for (int i = 8; i < 10; i++) begin
      GradValid = 1'b1; GradIn = g[i];
      tick();
      check("sim_drain_out", GradOut, f[i][DW-1] ? 32'd0 : g[i]);
    end
    GradValid = 1'b0;
    tick();

    // Clear with count 3 and a held output beat
    for (int i = 0; i < 4; i++) push_one(32'd5);
    GradValid = 1'b1; GradIn = 32'd55;
    tick();
    GradValid = 1'b0; GradOutReady = 1'b0;
    check("clr_pre_count", 32'(MaskCount), 32'd3);
    check("clr_pre_valid", 32'(GradOutValid), 32'd1);
    Clear = 1'b1; FwdValid = 1'b1; FwdData = -32'sd7;
    #1;
    check("clr_fwdrdy", 32'(FwdReady), 32'd0);
    check("clr_grdrdy", 32'(GradReady), 32'd0);
    tick();
    Clear = 1'b0;
    check("clr_count", 32'(MaskCount), 32'd0);
    check("clr_valid", 32'(GradOutValid), 32'd0);
    tick();
    FwdValid = 1'b0;
    check("clr_push_count", 32'(MaskCount), 32'd1);
    GradOutReady = 1'b1; GradValid = 1'b1; GradIn = 32'd9;
    tick();
    GradValid = 1'b0;
    check("clr_grad_valid", 32'(GradOutValid), 32'd1);
    check("clr_grad_out", GradOut, 32'd0);
    tick();

    // Async reset mid-stream
    push_one(32'd3); push_one(32'd4);
    GradValid = 1'b1; GradIn = 32'h1234;
    tick();
    GradValid = 1'b0; GradOutReady = 1'b0;
    check("ar_pre_out", GradOut, 32'h1234);
    #3 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(GradOutValid), 32'd0);
    check("ar_out", GradOut, 32'd0);
    check("ar_count", 32'(MaskCount), 32'd0);
    check("ar_fwdrdy", 32'(FwdReady), 32'd1);
    check("ar_grdrdy", 32'(GradReady), 32'd0);
    #7 rst_n = 1'b1;
    idle_inputs();
    tick();
    check("ar_post_fwdrdy", 32'(FwdReady), 32'd1);
    check("ar_post_grdrdy", 32'(GradReady), 32'd0);
    check("ar_post_count", 32'(MaskCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
